// File: rtl/pla_bist_pkg.sv
// pla_bist_pkg: shared FSM states, MISR polynomial, LFSR taps and mode codes
package pla_bist_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
   localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
   localparam int LFSR_TAP_HI = 19;
   localparam int LFSR_TAP_LO = 16;
   localparam logic MODE_CNT = 1'b0;
   localparam logic MODE_LFSR = 1'b1;
endpackage

// File: rtl/pla_bist_misr.sv
// pla_bist_misr: serial-input MISR compacting one response bit per enabled cycle
module pla_bist_misr
   import pla_bist_pkg::*;
#(
   parameter int SIG_W = 32,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             d,
   output logic [SIG_W-1:0] sig
);
   logic [SIG_W-1:0] nxt;
   assign nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(d);
   always_ff @(posedge clk or posedge rst)
      if (rst) sig <= '0;
      else sig <= clr ? '0 : en ? nxt : sig;
endmodule

// File: rtl/pla_bist_sequencer.sv
// pla_bist_sequencer: drives counter/LFSR vectors into a PLA netlist and compacts its response.
// Define PLA_BIST_YREG_EN to register y_in before compaction (adds a DRAIN cycle).
module pla_bist_sequencer
   import pla_bist_pkg::*;
#(
   parameter int N_IN = 20,
   parameter int SIG_W = 32,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [N_IN-1:0]  seed,
   input  logic [N_IN:0]    num_vec,
   output logic [N_IN-1:0]  x_out,
   output logic             x_vld,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic [N_IN:0]    ones_cnt
);
   state_t state, nxt;
   logic [N_IN:0] rem;
   logic md, acc, smp, last, y_d, y_en;
   logic [N_IN-1:0] nx, v0;
   assign acc = state == IDLE && start;
   assign smp = state == DRIVE;
   assign last = rem == (N_IN+1)'(1);
   assign nx = md == MODE_LFSR ? {x_out[N_IN-2:0], x_out[LFSR_TAP_HI] ^ x_out[LFSR_TAP_LO]}
                               : x_out + 1'b1;
   // an all-zero LFSR state would lock up, so it is replaced by 1
   assign v0 = (mode == MODE_LFSR && seed == '0) ? N_IN'(1) : seed;
   assign x_vld = smp;
   assign busy = state != IDLE;
   assign done = state == DONE;
`ifdef PLA_BIST_YREG_EN
   logic y_r, v_r;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         y_r <= 1'b0;
         v_r <= 1'b0;
      end else begin
         y_r <= y_in;
         v_r <= smp;
      end
   assign y_d = y_r;
   assign y_en = v_r;
`else
   assign y_d = y_in;
   assign y_en = smp;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = start ? (num_vec == '0 ? DONE : DRIVE) : IDLE;
`ifdef PLA_BIST_YREG_EN
         DRIVE: nxt = last ? DRAIN : DRIVE;
`else
         DRIVE: nxt = last ? DONE : DRIVE;
`endif
         DRAIN: nxt = DONE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         x_out <= '0;
         rem <= '0;
         md <= MODE_CNT;
         ones_cnt <= '0;
      end else if (acc) begin
         x_out <= v0;
         rem <= num_vec;
         md <= mode;
         ones_cnt <= '0;
      end else begin
         if (smp && !last) begin
            x_out <= nx;
            rem <= rem - 1'b1;
         end
         if (y_en) ones_cnt <= ones_cnt + (N_IN+1)'(y_d);
      end
   pla_bist_misr #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
      .clk(clk),
      .rst(rst),
      .clr(acc),
      .en(y_en),
      .d(y_d),
      .sig(signature)
   );
endmodule

// File: tb/tb_pla_bist_sequencer.sv
// tb_pla_bist_sequencer: directed and randomized runs against a vector-list reference model
module tb_pla_bist_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
   logic [19:0] seed = '0, x_out;
   logic [20:0] num_vec = '0, ones_cnt;
   logic x_vld, busy, done, y_in;
   logic [31:0] signature;
   int checks = 0, errors = 0, ymode = 0;
   logic [19:0] key = '0;
`ifdef PLA_BIST_YREG_EN
   localparam int XTRA = 1;
`else
   localparam int XTRA = 0;
`endif

   pla_bist_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .num_vec(num_vec),
      .x_out(x_out), .x_vld(x_vld), .y_in(y_in), .busy(busy), .done(done),
      .signature(signature), .ones_cnt(ones_cnt)
   );

   always #5 clk = ~clk;

   // stand-in netlist: constant 0, constant 1, or a keyed nonlinear function of x
   assign y_in = (ymode == 0) ? 1'b0 : (ymode == 1) ? 1'b1 :
                 ((^(x_out & key)) ^ (x_out[4:0] > 5'd12));

   function automatic logic yfun(input logic [19:0] x);
      return (ymode == 0) ? 1'b0 : (ymode == 1) ? 1'b1 : ((^(x & key)) ^ (x[4:0] > 5'd12));
   endfunction

   function automatic logic [19:0] nextv(input logic m, input logic [19:0] v);
      int unsigned vv;
      vv = v;
      return m ? 20'(((vv * 2) % 1048576) | (((vv >> 19) ^ (vv >> 16)) & 1))
               : 20'((vv + 1) % 1048576);
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic y);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {31'h0, y};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input logic m, input logic [19:0] s, input int n, input int ym,
                      input bit poke);
      logic [19:0] ev, lastv;
      logic [31:0] es;
      int eo, seen, cyc;
      bit ok;
      logic y;
      es = '0; eo = 0; seen = 0; ok = 1'b1;
      ymode = ym;
      key = 20'($urandom);
      @(negedge clk);
      mode = m; seed = s; num_vec = 21'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ev = (m && s == '0) ? 20'd1 : s;
      lastv = ev;
      cyc = 1;
      while (done !== 1'b1 && cyc < n + 8) begin
         if (busy !== 1'b1) ok = 1'b0;
         if (x_vld === 1'b1) begin
            if (x_out !== ev) ok = 1'b0;
            y = yfun(ev);
            es = misr(es, y);
            eo += int'(y);
            seen++;
            lastv = ev;
            ev = nextv(m, ev);
         end
         if (poke && cyc == 3) begin
            start = 1'b1; seed = 20'($urandom); num_vec = 21'd2; mode = ~m;
         end else start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk("done_latency", 64'(cyc), 64'(n + 1 + (n > 0 ? XTRA : 0)));
      chk("busy_in_done", 64'(busy), 64'(1));
      chk("sample_count", 64'(seen), 64'(n));
      chk("vector_seq", 64'(ok), 64'(1));
      chk("signature", 64'(signature), 64'(es));
      chk("ones_cnt", 64'(ones_cnt), 64'(eo));
      if (n > 0) chk("x_hold", 64'(x_out), 64'(lastv));
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("done_pulse", 64'(done), 64'(0));
      chk("sig_held", 64'(signature), 64'(es));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x_out", 64'(x_out), 64'(0));
      chk("rst_x_vld", 64'(x_vld), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_sig", 64'(signature), 64'(0));
      chk("rst_ones", 64'(ones_cnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      run(1'b0, 20'h0, 4, 1, 1'b0);
      chk("t1_sig_const", 64'(signature), 64'h0000000F);
      chk("t1_ones_const", 64'(ones_cnt), 64'd4);
      run(1'b0, 20'hFFFFE, 4, 2, 1'b0);
      chk("t2_wrap_last", 64'(x_out), 64'h00001);
      run(1'b1, 20'h0, 3, 0, 1'b0);
      chk("t3_lfsr_last", 64'(x_out), 64'h00004);
      chk("t3_sig_zero", 64'(signature), 64'h0);
      run(1'b0, 20'($urandom), 0, 2, 1'b0);
      run(1'b0, 20'h0, 8, 2, 1'b1);
      for (int i = 0; i < 8; i++)
         run(1'($urandom), 20'($urandom), int'($urandom_range(1, 300)), 2, 1'b0);
      run(1'b1, 20'h80000, 40, 1, 1'b0);
      chk("pre_rst_sig_nonzero", 64'(signature != 0), 64'(1));
      @(negedge clk);
      mode = 1'b0; seed = 20'($urandom); num_vec = 21'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_x_out", 64'(x_out), 64'(0));
      chk("mid_rst_x_vld", 64'(x_vld), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_sig", 64'(signature), 64'(0));
      chk("mid_rst_ones", 64'(ones_cnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", 64'(busy), 64'(0));
      run(1'b1, 20'($urandom), 100, 2, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
